// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the CPU datapath and its ALU.
//   WORD_W     - data/bus width
//   Z_W        - width of the ALU result and the Z register
//   NUM_REGS   - general-purpose register count
//   OP_*       - 5-bit ALU opcodes
package cpu_pkg;

    localparam int WORD_W   = 32;
    localparam int Z_W      = 64;
    localparam int NUM_REGS = 16;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/cpu_datapath_alu.sv
// alu: purely combinational 32-bit ALU with a 64-bit result.
//   a      in  32  first operand (Y register)
//   b      in  32  second operand (bus)
//   opcode in   5  operation select (OP_* in cpu_pkg)
//   c      out 64  result; upper half is zero except for MUL and DIV
module alu
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [4:0]        opcode,
    output logic [Z_W-1:0]    c
);

    logic signed [WORD_W-1:0] a_s;
    logic signed [WORD_W-1:0] b_s;
    logic signed [Z_W-1:0]    a_ext;
    logic signed [Z_W-1:0]    b_ext;
    logic [4:0]               sh;
    logic [5:0]               sh_inv;

    assign a_s    = $signed(a);
    assign b_s    = $signed(b);
    assign a_ext  = $signed({{WORD_W{a[WORD_W-1]}}, a});
    assign b_ext  = $signed({{WORD_W{b[WORD_W-1]}}, b});
    assign sh     = b[4:0];
    // A shift by 32 yields zero, so rotate-by-0 degenerates cleanly to a.
    assign sh_inv = 6'd32 - {1'b0, sh};

    always_comb begin
        c = '0;
        case (opcode)
            OP_ADD, OP_ADDI: c = {32'b0, a + b};
            OP_SUB:          c = {32'b0, a - b};
            OP_AND, OP_ANDI: c = {32'b0, a & b};
            OP_OR,  OP_ORI:  c = {32'b0, a | b};
            OP_SHR:          c = {32'b0, a >> sh};
            OP_SHRA:         c = {32'b0, $unsigned(a_s >>> sh)};
            OP_SHL:          c = {32'b0, a << sh};
            OP_ROR:          c = {32'b0, (a >> sh) | (a << sh_inv)};
            OP_ROL:          c = {32'b0, (a << sh) | (a >> sh_inv)};
            OP_MUL:          c = $unsigned(a_ext * b_ext);
            OP_DIV: begin
                // Remainder in the high half, quotient in the low half.
                if (b != '0) begin
                    c = {$unsigned(a_s % b_s), $unsigned(a_s / b_s)};
                end
            end
            OP_NEG:          c = {32'b0, 32'd0 - b};
            OP_NOT:          c = {32'b0, ~b};
            default:         c = '0;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: bus-based 32-bit datapath (register file, HI/LO/PC/IR/MAR/
// MDR/Y/Z registers, single bus mux, ALU). No sequencing of its own: the
// control unit drives all enables, selects and the ALU opcode.
//   clk, clr              clock, synchronous active-high clear
//   R*in/HIin/Loin/...    register load enables (Zin/ZHIin/ZLOin for Z)
//   R*out/HIout/...       bus source selects, fixed priority R0 highest
//   MDRread               MDR input: 1 = Mdatain, 0 = bus
//   IncPC                 PC <= PC + 1 when PCin is low
//   ALU_opcode            ALU operation (A = Y, B = bus)
//   Mdatain               memory read data
//   R0..R15, HI, LO, Y, ZLO, ZHI, IR, BusMuxOut, Z_register  observation
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic              R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic              HIin,
    input  logic              Loin,
    input  logic              PCin,
    input  logic              MDRin,
    input  logic              MARin,
    input  logic              IRin,
    input  logic              Yin,
    input  logic              Zin,
    input  logic              ZHIin,
    input  logic              ZLOin,
    input  logic              R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic              R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic              HIout,
    input  logic              Loout,
    input  logic              PCout,
    input  logic              MDRout,
    input  logic              ZHIout,
    input  logic              ZLOout,
    input  logic              ZHighSelect,
    input  logic              ZLowSelect,
    input  logic              InPortout,
    input  logic              Cout,
    input  logic              Yout,
    input  logic              MDRread,
    input  logic              IncPC,
    input  logic [4:0]        ALU_opcode,
    input  logic [WORD_W-1:0] Mdatain,
    output logic [WORD_W-1:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
    output logic [WORD_W-1:0] R8,  R9,  R10, R11, R12, R13, R14, R15,
    output logic [WORD_W-1:0] HI,
    output logic [WORD_W-1:0] LO,
    output logic [WORD_W-1:0] Y,
    output logic [WORD_W-1:0] ZLO,
    output logic [WORD_W-1:0] ZHI,
    output logic [WORD_W-1:0] IR,
    output logic [WORD_W-1:0] BusMuxOut,
    output logic [Z_W-1:0]    Z_register
);

    logic [NUM_REGS-1:0] r_in;
    logic [NUM_REGS-1:0] r_out;
    logic [WORD_W-1:0]   reg_file [NUM_REGS];
    logic [WORD_W-1:0]   bus_value;
    logic                reg_hit;
    logic [WORD_W-1:0]   c_imm;
    logic [Z_W-1:0]      alu_c;

    logic [WORD_W-1:0] hi_d,  hi_q;
    logic [WORD_W-1:0] lo_d,  lo_q;
    logic [WORD_W-1:0] pc_d,  pc_q;
    logic [WORD_W-1:0] ir_d,  ir_q;
    logic [WORD_W-1:0] mar_d, mar_q;
    logic [WORD_W-1:0] mdr_d, mdr_q;
    logic [WORD_W-1:0] y_d,   y_q;
    logic [WORD_W-1:0] zhi_d, zhi_q;
    logic [WORD_W-1:0] zlo_d, zlo_q;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Immediate field IR[18:0], sign-extended.
    assign c_imm = {{(WORD_W-19){ir_q[18]}}, ir_q[18:0]};

    // General-purpose registers, one flop bank per index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            logic [WORD_W-1:0] r_d, r_q;
            always_comb begin
                r_d = r_in[gi] ? bus_value : r_q;
            end
            always_ff @(posedge clk) begin
                if (clr) r_q <= '0;
                else     r_q <= r_d;
            end
            assign reg_file[gi] = r_q;
        end
    endgenerate

    // Bus mux: lowest-numbered general register wins, then the fixed
    // priority chain of special sources; idle bus reads zero.
    always_comb begin
        bus_value = '0;
        reg_hit   = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_out[i] && !reg_hit) begin
                bus_value = reg_file[i];
                reg_hit   = 1'b1;
            end
        end
        if (!reg_hit) begin
            if      (HIout)                 bus_value = hi_q;
            else if (Loout)                 bus_value = lo_q;
            else if (ZHIout || ZHighSelect) bus_value = zhi_q;
            else if (ZLOout || ZLowSelect)  bus_value = zlo_q;
            else if (PCout)                 bus_value = pc_q;
            else if (MDRout)                bus_value = mdr_q;
            else if (InPortout)             bus_value = '0;
            else if (Cout)                  bus_value = c_imm;
            else if (Yout)                  bus_value = y_q;
        end
    end

    alu u_alu (
        .a      (y_q),
        .b      (bus_value),
        .opcode (ALU_opcode),
        .c      (alu_c)
    );

    always_comb begin
        hi_d  = HIin  ? bus_value : hi_q;
        lo_d  = Loin  ? bus_value : lo_q;
        ir_d  = IRin  ? bus_value : ir_q;
        mar_d = MARin ? bus_value : mar_q;
        y_d   = Yin   ? bus_value : y_q;
        mdr_d = mdr_q;
        if (MDRin) mdr_d = MDRread ? Mdatain : bus_value;
        // An explicit PC load beats the increment.
        pc_d = pc_q;
        if (PCin)       pc_d = bus_value;
        else if (IncPC) pc_d = pc_q + 32'd1;
        zhi_d = (Zin || ZHIin) ? alu_c[63:32] : zhi_q;
        zlo_d = (Zin || ZLOin) ? alu_c[31:0]  : zlo_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            zhi_q <= '0;
            zlo_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            zhi_q <= zhi_d;
            zlo_q <= zlo_d;
        end
    end

    assign R0  = reg_file[0];
    assign R1  = reg_file[1];
    assign R2  = reg_file[2];
    assign R3  = reg_file[3];
    assign R4  = reg_file[4];
    assign R5  = reg_file[5];
    assign R6  = reg_file[6];
    assign R7  = reg_file[7];
    assign R8  = reg_file[8];
    assign R9  = reg_file[9];
    assign R10 = reg_file[10];
    assign R11 = reg_file[11];
    assign R12 = reg_file[12];
    assign R13 = reg_file[13];
    assign R14 = reg_file[14];
    assign R15 = reg_file[15];
    assign HI         = hi_q;
    assign LO         = lo_q;
    assign Y          = y_q;
    assign ZLO        = zlo_q;
    assign ZHI        = zhi_q;
    assign IR         = ir_q;
    assign BusMuxOut  = bus_value;
    assign Z_register = {zhi_q, zlo_q};

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

    // Load-enable vector indices
    localparam int L_HI = 0, L_LO = 1, L_PC = 2, L_MDR = 3, L_MAR = 4;
    localparam int L_IR = 5, L_Y = 6, L_Z = 7, L_ZHI = 8, L_ZLO = 9;
    // Bus-source vector indices
    localparam int S_HI = 0, S_LO = 1, S_ZHI = 2, S_ZHS = 3, S_ZLO = 4, S_ZLS = 5;
    localparam int S_PC = 6, S_MDR = 7, S_IN = 8, S_C = 9, S_Y = 10;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic [9:0]  ld;
    logic [10:0] src;
    logic        MDRread;
    logic        IncPC;
    logic [4:0]  ALU_opcode;
    logic [31:0] Mdatain;
    logic [31:0] r_val [16];
    logic [31:0] HI, LO, Y, ZLO, ZHI, IR, BusMuxOut;
    logic [63:0] Z_register;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .clk(clk), .clr(clr),
        .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
        .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
        .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .HIin(ld[L_HI]), .Loin(ld[L_LO]), .PCin(ld[L_PC]), .MDRin(ld[L_MDR]),
        .MARin(ld[L_MAR]), .IRin(ld[L_IR]), .Yin(ld[L_Y]), .Zin(ld[L_Z]),
        .ZHIin(ld[L_ZHI]), .ZLOin(ld[L_ZLO]),
        .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
        .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
        .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .HIout(src[S_HI]), .Loout(src[S_LO]), .PCout(src[S_PC]), .MDRout(src[S_MDR]),
        .ZHIout(src[S_ZHI]), .ZLOout(src[S_ZLO]), .ZHighSelect(src[S_ZHS]),
        .ZLowSelect(src[S_ZLS]), .InPortout(src[S_IN]), .Cout(src[S_C]), .Yout(src[S_Y]),
        .MDRread(MDRread), .IncPC(IncPC), .ALU_opcode(ALU_opcode), .Mdatain(Mdatain),
        .R0(r_val[0]),   .R1(r_val[1]),   .R2(r_val[2]),   .R3(r_val[3]),
        .R4(r_val[4]),   .R5(r_val[5]),   .R6(r_val[6]),   .R7(r_val[7]),
        .R8(r_val[8]),   .R9(r_val[9]),   .R10(r_val[10]), .R11(r_val[11]),
        .R12(r_val[12]), .R13(r_val[13]), .R14(r_val[14]), .R15(r_val[15]),
        .HI(HI), .LO(LO), .Y(Y), .ZLO(ZLO), .ZHI(ZHI), .IR(IR),
        .BusMuxOut(BusMuxOut), .Z_register(Z_register)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic clear_ctrl();
        r_in = '0; r_out = '0; ld = '0; src = '0;
        MDRread = 1'b0; IncPC = 1'b0; ALU_opcode = 5'b0; Mdatain = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; MDRread = 1'b1; ld[L_MDR] = 1'b1;
        tick();
        clear_ctrl();
    endtask

    task automatic load_r(input int idx, input logic [31:0] v);
        load_mdr(v);
        src[S_MDR] = 1'b1; r_in[idx] = 1'b1;
        tick();
        clear_ctrl();
    endtask

    task automatic load_special(input int ld_idx, input logic [31:0] v);
        load_mdr(v);
        src[S_MDR] = 1'b1; ld[ld_idx] = 1'b1;
        tick();
        clear_ctrl();
    endtask

    // Y <= a, then bus = b (via MDR), opcode op, Z enables per zmask {ZLO,ZHI,Z}
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic [2:0] zmask);
        load_special(L_Y, a);
        load_mdr(b);
        src[S_MDR] = 1'b1; ALU_opcode = op;
        ld[L_Z] = zmask[0]; ld[L_ZHI] = zmask[1]; ld[L_ZLO] = zmask[2];
        tick();
        clear_ctrl();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] got;
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i < 16) got = r_val[i];
            else case (i)
                16: got = HI;  17: got = LO;  18: got = Y;
                19: got = ZLO; 20: got = ZHI; default: got = IR;
            endcase
            tests++;
            if (got !== 32'h0) begin
                fails++;
                $display("[TB] FAIL reset_reg%0d got=%h exp=00000000", i, got);
            end else $display("[TB] ok reset_reg%0d", i);
        end
        tests++;
        if (BusMuxOut !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_bus got=%h exp=00000000", BusMuxOut);
        end else $display("[TB] ok reset_bus");
    endtask

    task automatic test_mem_load();
        Mdatain = 32'h0000000F; MDRread = 1'b1; ld[L_MDR] = 1'b1;
        tick();
        clear_ctrl();
        src[S_MDR] = 1'b1; r_in[6] = 1'b1;
        tick();
        clear_ctrl();
        tests++;
        if (r_val[6] !== 32'h0000000F) begin
            fails++;
            $display("[TB] FAIL mem_load_r6 got=%h exp=0000000f", r_val[6]);
        end else $display("[TB] ok mem_load_r6 %h", r_val[6]);
    endtask

    task automatic test_not();
        load_r(1, 32'h12);
        load_special(L_Y, 32'h0);
        src[S_Y] = 1'b1; r_out[1] = 1'b1; ALU_opcode = 5'b10010; ld[L_Z] = 1'b1;
        #1;
        tests++;
        if (BusMuxOut !== 32'h12) begin
            fails++;
            $display("[TB] FAIL not_bus got=%h exp=00000012", BusMuxOut);
        end else $display("[TB] ok not_bus %h", BusMuxOut);
        tick();
        clear_ctrl();
        tests++;
        if (Z_register !== 64'h00000000_FFFFFFED) begin
            fails++;
            $display("[TB] FAIL not_z got=%h exp=00000000ffffffed", Z_register);
        end else $display("[TB] ok not_z %h", Z_register);
    endtask

    task automatic test_add();
        load_r(3, 32'h4);
        r_out[3] = 1'b1; ld[L_Y] = 1'b1;
        tick();
        clear_ctrl();
        r_out[6] = 1'b1; ALU_opcode = 5'b00011; ld[L_Z] = 1'b1;
        tick();
        clear_ctrl();
        tests++;
        if (ZLO !== 32'h13 || ZHI !== 32'h0) begin
            fails++;
            $display("[TB] FAIL add_z got=%h_%h exp=00000000_00000013", ZHI, ZLO);
        end else $display("[TB] ok add_z %h", ZLO);
    endtask

    task automatic test_mul_div();
        run_op(32'h00010000, 32'h00010000, 5'b01111, 3'b001);
        tests++;
        if (ZHI !== 32'h1 || ZLO !== 32'h0) begin
            fails++;
            $display("[TB] FAIL mul_z got=%h_%h exp=00000001_00000000", ZHI, ZLO);
        end else $display("[TB] ok mul_z %h", Z_register);
        run_op(32'h13, 32'h4, 5'b10000, 3'b001);
        tests++;
        if (ZHI !== 32'h3 || ZLO !== 32'h4) begin
            fails++;
            $display("[TB] FAIL div_z got=%h_%h exp=00000003_00000004", ZHI, ZLO);
        end else $display("[TB] ok div_z %h", Z_register);
    endtask

    task automatic test_alu_ops();
        logic [31:0] ta [21] = '{32'h5, 32'hF0F0, 32'hF0F0, 32'h80000000, 32'h80000000,
            32'h1, 32'h1, 32'h80000001, 32'h12345678, 32'h1, 32'hFF, 32'hF0,
            32'hFFFFFFFE, 32'hFFFFFFF9, 32'h5, 32'h0, 32'h7, 32'h100, 32'hFFFFFFFF,
            32'h0, 32'h7};
        logic [31:0] tb_ [21] = '{32'h7, 32'hFF00, 32'h0F0F, 32'h4, 32'h4,
            32'd31, 32'h1, 32'h4, 32'h0, 32'h2, 32'h0F, 32'h0F,
            32'h3, 32'h2, 32'h0, 32'h5, 32'h9, 32'h24, 32'h1,
            32'h1, 32'h9};
        logic [4:0] top [21] = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
            5'b01001, 5'b01010, 5'b01011, 5'b01010, 5'b01100, 5'b01101, 5'b01110,
            5'b01111, 5'b10000, 5'b10000, 5'b10001, 5'b00000, 5'b00111, 5'b00011,
            5'b10001, 5'b10011};
        logic [63:0] texp [21] = '{64'h00000000_FFFFFFFE, 64'h0000F000, 64'h0000FFFF,
            64'h08000000, 64'hF8000000, 64'h80000000, 64'h80000000, 64'h00000018,
            64'h12345678, 64'h3, 64'h0F, 64'hFF,
            64'hFFFFFFFF_FFFFFFFA, 64'hFFFFFFFF_FFFFFFFD, 64'h0, 64'hFFFFFFFB,
            64'h0, 64'h10, 64'h0, 64'hFFFFFFFF, 64'h0};
        for (int i = 0; i < 21; i++) begin
            run_op(ta[i], tb_[i], top[i], 3'b001);
            tests++;
            if (Z_register !== texp[i]) begin
                fails++;
                $display("[TB] FAIL alu_op%0d opc=%b a=%h b=%h got=%h exp=%h",
                         i, top[i], ta[i], tb_[i], Z_register, texp[i]);
            end else $display("[TB] ok alu_op%0d opc=%b z=%h", i, top[i], Z_register);
        end
    endtask

    task automatic test_z_halves();
        logic [31:0] ta [5]   = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFE, 32'h1};
        logic [31:0] tb_ [5]  = '{32'h5, 32'h3, 32'h4, 32'h3, 32'h2};
        logic [4:0]  top [5]  = '{5'b10001, 5'b01111, 5'b01001, 5'b01111, 5'b00011};
        logic [2:0]  tz [5]   = '{3'b001, 3'b010, 3'b110, 3'b010, 3'b100};
        logic [63:0] texp [5] = '{64'h00000000_FFFFFFFB, 64'hFFFFFFFF_FFFFFFFB,
            64'h00000000_00000010, 64'hFFFFFFFF_00000010, 64'hFFFFFFFF_00000003};
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb_[i], top[i], tz[i]);
            tests++;
            if (Z_register !== texp[i]) begin
                fails++;
                $display("[TB] FAIL z_half%0d en=%b got=%h exp=%h", i, tz[i], Z_register, texp[i]);
            end else $display("[TB] ok z_half%0d z=%h", i, Z_register);
        end
    endtask

    task automatic test_bus_priority();
        logic [15:0] rsel [12] = '{16'h0024, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0,
            16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [10:0] ssel [12];
        logic [31:0] exp_bus [12] = '{32'hAA, 32'hBB, 32'h11, 32'h22, 32'hFFFFFFFF,
            32'h3, 32'h0, 32'h33, 32'h0, 32'hFFFC0001, 32'h33, 32'h0};
        ssel[0]  = '0;
        ssel[1]  = 11'(1) << S_HI;
        ssel[2]  = (11'(1) << S_HI)  | (11'(1) << S_LO);
        ssel[3]  = (11'(1) << S_LO)  | (11'(1) << S_ZHI);
        ssel[4]  = (11'(1) << S_ZHS) | (11'(1) << S_ZLO);
        ssel[5]  = (11'(1) << S_ZLS) | (11'(1) << S_PC);
        ssel[6]  = (11'(1) << S_PC)  | (11'(1) << S_MDR);
        ssel[7]  = (11'(1) << S_MDR) | (11'(1) << S_IN);
        ssel[8]  = (11'(1) << S_IN)  | (11'(1) << S_C);
        ssel[9]  = (11'(1) << S_C)   | (11'(1) << S_Y);
        ssel[10] = 11'(1) << S_Y;
        ssel[11] = '0;
        load_r(2, 32'hAA);
        load_r(5, 32'hBB);
        load_special(L_HI, 32'h11);
        load_special(L_LO, 32'h22);
        load_special(L_IR, 32'h00040001);
        load_special(L_Y, 32'h33);
        tests++;
        if (IR !== 32'h00040001) begin
            fails++;
            $display("[TB] FAIL ir_load got=%h exp=00040001", IR);
        end else $display("[TB] ok ir_load %h", IR);
        for (int i = 0; i < 12; i++) begin
            r_out = rsel[i]; src = ssel[i];
            #1;
            tests++;
            if (BusMuxOut !== exp_bus[i]) begin
                fails++;
                $display("[TB] FAIL bus_prio%0d rsel=%h ssel=%b got=%h exp=%h",
                         i, rsel[i], ssel[i], BusMuxOut, exp_bus[i]);
            end else $display("[TB] ok bus_prio%0d bus=%h", i, BusMuxOut);
        end
        clear_ctrl();
    endtask

    task automatic test_pc_reset();
        IncPC = 1'b1;
        repeat (3) tick();
        clear_ctrl();
        src[S_PC] = 1'b1;
        #1;
        tests++;
        if (BusMuxOut !== 32'h3) begin
            fails++;
            $display("[TB] FAIL pc_inc got=%h exp=00000003", BusMuxOut);
        end else $display("[TB] ok pc_inc %h", BusMuxOut);
        // Self-transfer: PCin beats IncPC, old PC written back
        ld[L_PC] = 1'b1; IncPC = 1'b1;
        tick();
        clear_ctrl();
        src[S_PC] = 1'b1;
        #1;
        tests++;
        if (BusMuxOut !== 32'h3) begin
            fails++;
            $display("[TB] FAIL pc_self got=%h exp=00000003", BusMuxOut);
        end else $display("[TB] ok pc_self %h", BusMuxOut);
        clear_ctrl();
        // Reset overrides enables
        clr = 1'b1; r_in[6] = 1'b1; src[S_MDR] = 1'b1; ld[L_Z] = 1'b1; ld[L_Y] = 1'b1;
        ALU_opcode = 5'b10010; IncPC = 1'b1;
        tick();
        clr = 1'b0;
        clear_ctrl();
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (r_val[i] !== 32'h0) begin
                fails++;
                $display("[TB] FAIL clr_r%0d got=%h exp=00000000", i, r_val[i]);
            end else $display("[TB] ok clr_r%0d", i);
        end
        tests++;
        if ({HI, LO, Y, IR} !== 128'h0 || Z_register !== 64'h0) begin
            fails++;
            $display("[TB] FAIL clr_special got hi=%h lo=%h y=%h ir=%h z=%h exp=0",
                     HI, LO, Y, IR, Z_register);
        end else $display("[TB] ok clr_special");
        src[S_PC] = 1'b1;
        #1;
        tests++;
        if (BusMuxOut !== 32'h0) begin
            fails++;
            $display("[TB] FAIL clr_pc got=%h exp=00000000", BusMuxOut);
        end else $display("[TB] ok clr_pc");
        src = '0; src[S_MDR] = 1'b1;
        #1;
        tests++;
        if (BusMuxOut !== 32'h0) begin
            fails++;
            $display("[TB] FAIL clr_mdr got=%h exp=00000000", BusMuxOut);
        end else $display("[TB] ok clr_mdr");
        clear_ctrl();
    endtask

    initial begin
        clr = 1'b1;
        clear_ctrl();
        test_reset();
        test_mem_load();
        test_not();
        test_add();
        test_mul_div();
        test_alu_ops();
        test_z_halves();
        test_bus_priority();
        test_pc_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Bus-based 32-bit CPU datapath holding the register file, special registers (HI, LO, PC, IR, MAR, MDR, Y, Z), a single 32-bit bus multiplexer and a combinational ALU with a 64-bit result. The control unit, or a bench, drives every register enable, bus-source select and ALU opcode directly; the block contains no sequencing of its own. It sits between the control unit and memory (memory data enters on `Mdatain`).

## Interface
No parameters; data width is fixed at 32, Z is 64.
- `clk`  in  1  single clock; all registers update on its rising edge
- `clr`  in  1  reset, synchronous, active-high
- `R0in`..`R15in`, `HIin`, `Loin`, `PCin`, `MDRin`, `MARin`, `IRin`, `Yin`  in  1 each  register load enables
- `Zin`, `ZHIin`, `ZLOin`  in  1 each  Z load enables: full 64 bits, high half only, low half only
- `R0out`..`R15out`, `HIout`, `Loout`, `PCout`, `MDRout`, `ZHIout`, `ZLOout`, `ZHighSelect`, `ZLowSelect`, `InPortout`, `Cout`, `Yout`  in  1 each  bus-source selects
- `MDRread`  in  1  MDR input mux: 1 = `Mdatain`, 0 = bus
- `IncPC`  in  1  PC increment
- `ALU_opcode`  in  5  ALU operation
- `Mdatain`  in  32  memory read data
- `R0`..`R15`, `HI`, `LO`, `Y`, `ZLO`, `ZHI`, `IR`  out  32 each  live register contents
- `BusMuxOut`  out  32  current bus value
- `Z_register`  out  64  {ZHI, ZLO}

## Operation
- Bus priority, highest first, one source wins: R0out..R15out in index order, then HIout, Loout, ZHIout|ZHighSelect, ZLOout|ZLowSelect, PCout, MDRout, InPortout, Cout, Yout. With no select asserted the bus is 0.
- InPortout drives 32'h0; this block has no input port.
- Cout drives IR[18:0] sign-extended to 32 bits.
- ALU: A = Y, B = BusMuxOut, result C is 64 bits. All ops other than MUL and DIV zero C[63:32].
- ALU_opcode decode:
  - 00011 ADD (A+B)
  - 00100 SUB (A−B)
  - 00101 AND
  - 00110 OR
  - 00111 SHR (logical, A >> B[4:0])
  - 01000 SHRA (arithmetic)
  - 01001 SHL
  - 01010 ROR
  - 01011 ROL
  - 01100 ADDI (= ADD)
  - 01101 ANDI (= AND)
  - 01110 ORI (= OR)
  - 01111 MUL: signed A×B, 64-bit
  - 10000 DIV: signed; C[31:0] = quotient, C[63:32] = remainder. Divide by 0 gives C = 0.
  - 10001 NEG (−B)
  - 10010 NOT (~B)
  - any other code gives C = 0
- Z loads:
  - Zin loads {ZHI, ZLO} ← C.
  - ZHIin loads ZHI ← C[63:32]; ZLOin loads ZLO ← C[31:0]. These two may combine with each other or with Zin with the same effect.
- MDR ← (MDRread ? Mdatain : bus) when MDRin is high.
- All other registers load from the bus when their `in` is high. MAR is internal.
- PC: PCin has priority and loads from the bus; otherwise IncPC loads PC+1.

## Timing
- `clr` high at a rising edge clears every register (R0–R15, HI, LO, PC, IR, MAR, MDR, Y, ZHI, ZLO) to 0.
  - Reset overrides all enables, including mid-operation.
- Bus and ALU are purely combinational, with zero-cycle latency.
- A register transfer completes at the first rising edge where the enable is high.
- ALU result is visible on Z one edge after the opcode, Y and the bus source are valid.
- Source and destination may be the same register: the old value is written.

## Structure
- Shared package `cpu_pkg`: 5-bit opcode localparams, word width constant.
- One sub-module: `alu` (combinational, A/B/opcode → 64-bit C).
- Registers and bus mux live in the top-level module.

## Test plan
- Memory load: Mdatain=0x0000000F, MDRread=1 and MDRin=1 for one edge; then MDRout=1 and R6in=1 for one edge → R6=0x0000000F.
- NOT: R1=0x12, Y=0; assert Yout and R1out, opcode 10010, Zin=1 → bus=0x12 (register priority over Y), ZLO=0xFFFFFFED, ZHI=0.
- ADD: R3=4, R6=0xF; R3out+Yin, then R6out, opcode 00011, Zin → ZLO=0x13.
- MUL/DIV:
  - Y=0x00010000, bus=0x00010000, opcode 01111 → ZHI=1, ZLO=0.
  - Y=0x13, bus=4, opcode 10000 → ZLO=4, ZHI=3.
- PC and reset:
  - IncPC for 3 edges from PC=0 → PC=3.
  - Then clr=1 together with R6in=1 → every register reads 0 after that edge.
